// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch port (if_*)
//   and the load/store data port (d_*). One transaction is in flight at a
//   time. The data port normally wins contested arbitration. After
//   STARVE_LIMIT consecutive contested data wins, fetch is forced through.
//   A transaction that spends TIMEOUT cycles in REQ+WAIT completes with an
//   error. TIMEOUT = 0 disables the timeout.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   if_req/if_addr  fetch request (held until if_rvalid)
//   if_rvalid/if_rdata/if_err  fetch completion pulse, data, error
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request (held until d_rvalid)
//   d_rvalid/d_rdata/d_err     data completion pulse, load data, error
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request side
//   mem_ready/mem_rvalid/mem_rdata               memory response side
//   busy            arbiter is not idle
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic          owner_d;            // 1 = data port owns the transaction
  logic [31:2]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          any_req, contested, force_fetch, pick_d, misaligned;
  logic          tmo_hit, req_done;
  logic [31:0]   grant_addr;

  // Arbitration decode, only acted on in IDLE.
  assign any_req     = if_req | d_req;
  assign contested   = if_req & d_req;
  assign force_fetch = contested && (starve_cnt == SW'(STARVE_LIMIT));
  assign pick_d      = d_req && !force_fetch;
  assign grant_addr  = pick_d ? d_addr : if_addr;
  // Only fetches are alignment-checked; data lanes come from d_wstrb.
  assign misaligned  = !pick_d && (grant_addr[1:0] != 2'b00);

  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign req_done = ((state == REQ) && mem_ready && mem_rvalid) ||
                    ((state == WAIT) && mem_rvalid);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (any_req) state_next = misaligned ? RESP : REQ;
      REQ: begin
        if (mem_ready && mem_rvalid) state_next = RESP;
        else if (tmo_hit)            state_next = RESP;
        else if (mem_ready)          state_next = WAIT;
      end
      WAIT: if (mem_rvalid || tmo_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (any_req) begin
          owner_d <= pick_d;
          addr_q  <= grant_addr[31:2];
          we_q    <= pick_d & d_we;
          wdata_q <= pick_d ? d_wdata : 32'h0;
          wstrb_q <= (pick_d && d_we) ? d_wstrb : 4'h0;
          rdata_q <= '0;
          err_q   <= misaligned;
          tmo_cnt <= '0;
          if (contested) starve_cnt <= force_fetch ? '0 : starve_cnt + 1'b1;
          else if (!d_req) starve_cnt <= '0;
        end
        REQ, WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A completion on the timeout cycle wins over the error.
          if (req_done) begin
            rdata_q <= we_q ? 32'h0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state and registers only.
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q, 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? wdata_q : 32'h0;
  assign mem_wstrb = mem_req ? wstrb_q : 4'h0;

  assign if_rvalid = (state == RESP) && !owner_d;
  assign d_rvalid  = (state == RESP) &&  owner_d;
  assign if_rdata  = if_rvalid ? rdata_q : 32'h0;
  assign if_err    = if_rvalid & err_q;
  assign d_rdata   = d_rvalid ? rdata_q : 32'h0;
  assign d_err     = d_rvalid & err_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected
// completions and a small behavioural memory with selectable response modes.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    bit          uses_mem;
    logic [31:0] maddr;
    bit          mwe;
    logic [3:0]  mstrb;
    logic [31:0] mwdata;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Memory model: 0 = ready+rvalid together, 1 = rvalid one cycle after ready,
  // 2 = ready but never rvalid.
  int          mode = 0;
  bit          inject = 0;
  bit          pend = 0;
  logic [31:0] pend_data;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h104) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (pend) begin
      mem_rvalid = 1'b1; mem_rdata = pend_data; pend = 1'b0;
    end
    if (inject) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; inject = 1'b0;
    end
    if (mem_req) begin
      mem_ready = 1'b1;
      if (mode == 0) begin
        mem_rvalid = 1'b1; mem_rdata = pat(mem_addr);
      end else if (mode == 1) begin
        pend = 1'b1; pend_data = pat(mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next completion and compare it with the scoreboard.
  task automatic wait_resp(input string tag, input int budget, output int lat);
    exp_t e;
    bit   got, seen;
    got = 0; seen = 0; lat = budget;
    check({tag, "_sb"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (mem_req && !seen) begin
        seen = 1;
        if (e.uses_mem) begin
          check({tag, "_maddr"}, mem_addr, e.maddr);
          check({tag, "_mwe"}, mem_we, e.mwe);
          check({tag, "_mstrb"}, mem_wstrb, e.mstrb);
          if (e.mwe) check({tag, "_mwdata"}, mem_wdata, e.mwdata);
        end
      end
      if (if_rvalid || d_rvalid) begin
        got = 1; lat = k; break;
      end
    end
    check({tag, "_done"}, got, 1);
    check({tag, "_memreq"}, seen, e.uses_mem);
    if (got) begin
      check({tag, "_d_rvalid"}, d_rvalid, e.is_d);
      check({tag, "_if_rvalid"}, if_rvalid, !e.is_d);
      if (e.is_d) begin
        check({tag, "_d_rdata"}, d_rdata, e.rdata);
        check({tag, "_d_err"}, d_err, e.err);
        check({tag, "_if_quiet"}, {if_rdata[30:0], if_err}, 0);
      end else begin
        check({tag, "_if_rdata"}, if_rdata, e.rdata);
        check({tag, "_if_err"}, if_err, e.err);
        check({tag, "_d_quiet"}, {d_rdata[30:0], d_err}, 0);
      end
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic inject_rvalid();
    @(posedge clk);
    inject = 1'b1;
  endtask

  function automatic exp_t mk(bit is_d, logic [31:0] rdata, bit err, bit uses_mem,
                              logic [31:0] maddr, bit mwe, logic [3:0] mstrb,
                              logic [31:0] mwdata);
    exp_t e;
    e.is_d = is_d; e.rdata = rdata; e.err = err; e.uses_mem = uses_mem;
    e.maddr = maddr; e.mwe = mwe; e.mstrb = mstrb; e.mwdata = mwdata;
    return e;
  endfunction

  initial begin
    int  lat;
    bit  seen;
    reset = 1'b1; if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Single fetch, memory answers rvalid one cycle after ready.
    mode = 1;
    sb.push_back(mk(0, 32'h0050_0093, 0, 1, 32'h104, 0, 4'h0, 32'h0));
    if_req = 1; if_addr = 32'h104;
    wait_resp("fetch", 10, lat);
    if_req = 0;
    check("fetch_lat", lat, 3);
    quiet("fetch_pulse", 2);

    // Store to an unaligned byte address; word address goes to memory.
    mode = 0;
    sb.push_back(mk(1, 32'h0, 0, 1, 32'h204, 1, 4'b0100, 32'h0000_AB00));
    d_req = 1; d_we = 1; d_addr = 32'h206; d_wdata = 32'h0000_AB00; d_wstrb = 4'b0100;
    wait_resp("store", 10, lat);
    d_req = 0; d_we = 0;
    check("store_lat", lat, 2);
    quiet("store_pulse", 2);

    // Load: byte enables must not reach memory on a read.
    mode = 1;
    sb.push_back(mk(1, pat(32'h308), 0, 1, 32'h308, 0, 4'h0, 32'h0));
    d_req = 1; d_we = 0; d_addr = 32'h30B; d_wstrb = 4'hF;
    wait_resp("load", 10, lat);
    d_req = 0;
    check("load_lat", lat, 3);
    quiet("load_pulse", 2);

    // Starvation: both ports held high, grant order D,D,D,F,D,D,D,F.
    mode = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) sb.push_back(mk(0, pat(32'h400), 0, 1, 32'h400, 0, 4'h0, 32'h0));
      else            sb.push_back(mk(1, pat(32'h300), 0, 1, 32'h300, 0, 4'h0, 32'h0));
    end
    if_req = 1; if_addr = 32'h400;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) begin
      wait_resp($sformatf("starve%0d", i), 10, lat);
      check($sformatf("starve%0d_lat", i), lat, (i == 0) ? 2 : 3);
    end
    if_req = 0; d_req = 0;
    quiet("starve_pulse", 2);

    // Timeout: ready accepted, rvalid never arrives.
    mode = 2;
    sb.push_back(mk(1, 32'h0, 1, 1, 32'h300, 0, 4'h0, 32'h0));
    d_req = 1; d_we = 0; d_addr = 32'h300;
    wait_resp("tmo", 30, lat);
    d_req = 0;
    check("tmo_lat", lat, 17);
    inject_rvalid();
    quiet("tmo_late_rvalid", 4);

    // Misaligned fetch completes with an error and never touches memory.
    mode = 0;
    sb.push_back(mk(0, 32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0));
    if_req = 1; if_addr = 32'h102;
    wait_resp("misalign", 6, lat);
    if_req = 0;
    check("misalign_lat", 32'(lat inside {1, 2}), 1);
    quiet("misalign_pulse", 2);

    // Reset while waiting for the memory, then a late rvalid.
    mode = 2;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    check("rstop_reached_req", seen, 1);
    repeat (2) @(negedge clk);
    check("rstop_busy_before", busy, 1);
    reset = 1'b1; d_req = 0;
    @(negedge clk);
    reset = 1'b0;
    check("rstop_busy", busy, 0);
    check("rstop_rvalid", {if_rvalid, d_rvalid}, 0);
    check("rstop_mem_req", mem_req, 0);
    inject_rvalid();
    quiet("rstop_late_rvalid", 4);
    check("rstop_busy_after", busy, 0);

    mode = 1;
    sb.push_back(mk(0, 32'h0050_0093, 0, 1, 32'h104, 0, 4'h0, 32'h0));
    if_req = 1; if_addr = 32'h104;
    wait_resp("rstop_fetch", 10, lat);
    if_req = 0;
    check("rstop_fetch_lat", lat, 3);
    quiet("rstop_fetch_pulse", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
